pll_lock_reset_seq: RTL and testbench
=====================================

Name: pll_lock_reset_seq

Overview:
- Sits directly downstream of the audio/CPU PLL and consumes its `locked` output.
- Also drives the PLL's `rst` input, so a PLL that fails to lock can be re-reset.
- Runs on the 50 MHz reference clock, which is valid before lock. It filters `locked` and releases the system reset only after a stable lock period.
- On loss of lock it re-asserts the system reset and restarts the PLL; lock losses and lock timeouts are counted for Nios/debug readout.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `pll_locked` (minimum 2).
- PLL_RST_CYCLES, 8, cycles `pll_rst` is held high per PLL reset attempt.
- LOCK_TIMEOUT, 65536, cycles to wait for lock before retrying the PLL reset.
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before `sys_rst` is released.
- CNT_W, 8, width of the event counters.

Ports:
- clk  in  1  50 MHz reference clock (same net as the PLL refclk)
- rst  in  1  synchronous, active-high block reset
- pll_locked  in  1  PLL locked output; asynchronous to clk
- pll_rst  out  1  reset to the PLL, active-high
- sys_rst  out  1  system reset request, active-high; each consuming domain synchronizes it locally
- ready  out  1  high only in RUN
- loss_count  out  CNT_W  number of RUN→lock-lost events, saturating
- retry_count  out  CNT_W  number of WAIT_LOCK timeouts, saturating

Behaviour:
- One clock; reset is synchronous and active-high.
- While rst=1, on every edge:
  - pll_rst=1, sys_rst=1, ready=0.
  - loss_count=0, retry_count=0.
  - Synchronizer flops cleared to 0.
  - state=PLL_RST, cnt=0.
- All outputs are registered. The FSM uses `locked_s`, which is `pll_locked` after SYNC_STAGES flops.
- A single counter `cnt` is shared across states. It is cleared on every state transition, and its width is sized for the largest of the three cycle parameters.
- PLL_RST:
  - pll_rst=1, sys_rst=1.
  - cnt increments each cycle.
  - At cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after rst falls (or after entry from another state).
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABLE.
  - Else, if cnt==LOCK_TIMEOUT-1, retry_count+1 (saturating at all-ones) and go to PLL_RST.
  - If locked_s and the timeout occur in the same cycle, lock wins: no retry increment.
- STABLE:
  - sys_rst=1.
  - If locked_s=0, go to WAIT_LOCK (glitch, no count change).
  - Else, if cnt==STABLE_CYCLES-1, go to RUN.
- RUN:
  - sys_rst=0, ready=1, pll_rst=0.
  - If locked_s=0: go to PLL_RST; sys_rst=1 and ready=0 on the next edge; loss_count+1 (saturating).
- Latency: with pll_locked held high from cycle L in WAIT_LOCK, sys_rst falls on the edge L+SYNC_STAGES+STABLE_CYCLES+1.
- Lock-loss detection: sys_rst rises SYNC_STAGES+1 edges after pll_locked falls.
- Counters never wrap. They are cleared only by rst.
- No combinational path exists from pll_locked to any output.

Test Plan (SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, CNT_W=4):
1. Power-up nominal: rst high 5 cycles then low; pll_locked rises 10 cycles after rst falls.
   - pll_rst high for exactly 4 cycles after rst falls.
   - sys_rst falls 19 edges after pll_locked first sampled high; ready rises on the same edge.
   - Both counters remain 0.
2. Glitch during STABLE: pll_locked high 8 cycles, low 1 cycle, then high.
   - No release at the first attempt.
   - sys_rst falls 19 edges after the second rising edge.
   - Counters remain 0.
3. Lock timeout: pll_locked held low.
   - pll_rst pulses 4 cycles high every 68 cycles.
   - retry_count increments 1,2,3… and saturates at 15 after 15 timeouts.
4. Loss of lock in RUN: drop pll_locked for 1 cycle.
   - sys_rst=1 and ready=0 three edges later; loss_count=1.
   - pll_rst high 4 cycles, then re-lock releases sys_rst again.
5. Simultaneous timeout and lock: locked_s first seen high exactly at cnt==63 in WAIT_LOCK.
   - Transition to STABLE; retry_count unchanged.
6. Reset mid-operation: assert rst while in STABLE and again in RUN.
   - Next edge: pll_rst=1, sys_rst=1, ready=0, counters 0.
   - After release, the full sequence restarts as in test 1.

Source files
------------

// File: rtl/pll_lock_reset_seq_if.sv
// PLL-facing and status signals of the lock/reset sequencer, bundled for port hookup.
// The slave side belongs to the sequencer; the master side belongs to whatever drives the PLL lock.
interface pll_lock_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic [CNT_W-1:0] retry_count;

  modport master (
    output pll_locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  loss_count,
    input  retry_count
  );

  modport slave (
    input  pll_locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output loss_count,
    output retry_count
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL reset/lock sequencer: filters the PLL lock, releases the system reset after a stable lock,
// and re-resets the PLL on lock timeout or lock loss while counting both events.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 8,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_reset_seq_if.slave  bus
);

  // One shared cycle counter has to reach the largest of the three cycle limits.
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       loss_q, loss_d;
  logic [CNT_W-1:0]       retry_q, retry_d;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    loss_d  = loss_q;
    retry_d = retry_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over the retry.
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          retry_d = (retry_q == '1) ? retry_q : retry_q + CNT_W'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = PLL_RST;
          loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_W'(1);
        end
      end
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs follow the next state so they change on the same edge as the transition.
    pll_rst_d = (state_d == PLL_RST);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
      retry_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_rst     = sys_rst_q;
  assign bus.ready       = ready_q;
  assign bus.loss_count  = loss_q;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq: expected outputs are queued against absolute
// clock edges when stimulus is driven and compared at the following negedge.
module tb_pll_lock_reset_seq;
  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 64;
  localparam int STABLE_CYCLES  = 16;
  localparam int CNT_W          = 4;

  typedef struct {
    int          cyc;
    string       tag;
    logic [10:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   now = 0;
  int   rel_edge = 0;
  exp_t sb_q[$];

  pll_lock_reset_seq_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_reset_seq #(
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] pack(logic pr, logic sr, logic rdy,
                                       logic [3:0] loss, logic [3:0] retry);
    return {pr, sr, rdy, loss, retry};
  endfunction

  task automatic checkOutput(string tag, logic [10:0] obs, logic [10:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("[TB] FAIL %s @edge %0d observed={pll_rst,sys_rst,ready,loss,retry}=%b required=%b",
             tag, cyc, obs, exp_v);
    end
  endtask

  // Pops every scoreboard entry that is due on the edge just past.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        checkOutput(sb_q[i].tag,
                    {bus.pll_rst, bus.sys_rst, bus.ready, bus.loss_count, bus.retry_count},
                    sb_q[i].val);
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s overdue: observed=unchecked required=%b at edge %0d",
                 sb_q[i].tag, sb_q[i].val, sb_q[i].cyc);
        sb_q.delete(i);
      end
    end
  end

  task automatic expectAt(int at, string tag, logic [10:0] v);
    exp_t e;
    e.cyc = at;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(logic r, logic l);
    rst            = r;
    bus.pll_locked = l;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
    now = cyc;
  endtask

  // Holds rst for 'hold' edges, then releases it with the PLL unlocked.
  task automatic startFromReset(int hold, string tag);
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i <= hold; i++) expectAt(now + i, {tag, "_rst"}, pack(1, 1, 0, 0, 0));
    tick(hold);
    rel_edge = now;
    applyStimulus(1'b0, 1'b0);
    expectAt(rel_edge + 1, {tag, "_pllrst_first"}, pack(1, 1, 0, 0, 0));
    expectAt(rel_edge + 3, {tag, "_pllrst_last"},  pack(1, 1, 0, 0, 0));
    expectAt(rel_edge + 4, {tag, "_pllrst_fall"},  pack(0, 1, 0, 0, 0));
  endtask

  // Locks the PLL after 'wait_c' cycles and follows it into RUN.
  task automatic lockAndRun(int wait_c, logic [3:0] loss, string tag);
    int l_edge;
    tick(wait_c);
    applyStimulus(1'b0, 1'b1);
    l_edge = now;
    expectAt(l_edge + 18, {tag, "_before_release"}, pack(0, 1, 0, loss, 0));
    expectAt(l_edge + 19, {tag, "_release"},        pack(0, 0, 1, loss, 0));
    tick(20);
  endtask

  initial begin
    int d_edge;
    int g_edge;
    int h_edge;
    int e;

    applyStimulus(1'b1, 1'b0);

    // Power-up: reset for 5 cycles, lock 10 cycles after release.
    startFromReset(5, "pwrup");
    lockAndRun(10, 4'd0, "pwrup");

    // One-cycle lock loss in RUN, then recovery through a fresh PLL reset.
    applyStimulus(1'b0, 1'b0);
    d_edge = now;
    tick(1);
    applyStimulus(1'b0, 1'b1);
    expectAt(d_edge + 2,  "loss_still_run",  pack(0, 0, 1, 0, 0));
    expectAt(d_edge + 3,  "loss_detect",     pack(1, 1, 0, 1, 0));
    expectAt(d_edge + 6,  "loss_pllrst_end", pack(1, 1, 0, 1, 0));
    expectAt(d_edge + 7,  "loss_wait_lock",  pack(0, 1, 0, 1, 0));
    expectAt(d_edge + 23, "loss_stable",     pack(0, 1, 0, 1, 0));
    expectAt(d_edge + 24, "loss_rerun",      pack(0, 0, 1, 1, 0));
    tick(26);

    // Reset while in RUN clears the loss counter and restarts the sequence.
    startFromReset(2, "rst_in_run");
    lockAndRun(10, 4'd0, "rst_in_run_restart");

    // Glitch on lock during STABLE must restart the stable period.
    startFromReset(2, "glitch");
    tick(10);
    applyStimulus(1'b0, 1'b1);
    g_edge = now;
    tick(8);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1);
    h_edge = now;
    expectAt(g_edge + 19, "glitch_no_release", pack(0, 1, 0, 0, 0));
    expectAt(h_edge + 18, "glitch_before",     pack(0, 1, 0, 0, 0));
    expectAt(h_edge + 19, "glitch_release",    pack(0, 0, 1, 0, 0));
    tick(21);

    // Reset while in STABLE.
    startFromReset(2, "stable_pre");
    tick(10);
    applyStimulus(1'b0, 1'b1);
    tick(8);
    expectAt(now, "in_stable", pack(0, 1, 0, 0, 0));
    tick(1);
    startFromReset(2, "rst_in_stable");
    lockAndRun(10, 4'd0, "rst_in_stable_restart");

    // Lock first synchronized exactly on the timeout cycle: lock wins.
    startFromReset(2, "simul");
    e = rel_edge;
    tick(65);
    applyStimulus(1'b0, 1'b1);
    expectAt(e + 67, "simul_pre",     pack(0, 1, 0, 0, 0));
    expectAt(e + 68, "simul_no_retry", pack(0, 1, 0, 0, 0));
    expectAt(e + 83, "simul_stable",  pack(0, 1, 0, 0, 0));
    expectAt(e + 84, "simul_run",     pack(0, 0, 1, 0, 0));
    tick(86 - (now - e));

    // Lock never arrives: periodic PLL reset pulses and saturating retry count.
    startFromReset(2, "timeout");
    e = rel_edge;
    for (int k = 1; k <= 16; k++) begin
      int r;
      int rp;
      r  = (k > 15) ? 15 : k;
      rp = (k - 1 > 15) ? 15 : k - 1;
      expectAt(e + 68 * k - 1, $sformatf("timeout%0d_pre", k),  pack(0, 1, 0, 0, 4'(rp)));
      expectAt(e + 68 * k,     $sformatf("timeout%0d_hit", k),  pack(1, 1, 0, 0, 4'(r)));
      expectAt(e + 68 * k + 3, $sformatf("timeout%0d_hold", k), pack(1, 1, 0, 0, 4'(r)));
      expectAt(e + 68 * k + 4, $sformatf("timeout%0d_end", k),  pack(0, 1, 0, 0, 4'(r)));
    end
    tick(68 * 16 + 8);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
